// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: flush, MEM bus wait with timeout, multi-cycle EX
// sequencing and a saturating stall-cycle statistic.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; ex_mc_start accepted
// BUSY  | multi-cycle op counting down, EX stage stopped
// DONE  | result ready (ex_mc_done), EX stall released, back to IDLE next cycle
module pipe_ctrl #(
  parameter int MC_W        = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            ex_mc_start,
  input  logic [MC_W-1:0] ex_mc_cycles,
  input  logic            mem_req,
  input  logic            mem_ack,
  input  logic            flush_req,
  input  logic [31:0]     flush_pc,
  input  logic            stat_clr,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [31:0]     new_pc,
  output logic            ex_mc_done,
  output logic            bus_err,
  output logic [31:0]     stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]      TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [5:0]      ST_NONE  = 6'b000000;
  localparam logic [5:0]      ST_ID    = 6'b000111;
  localparam logic [5:0]      ST_EX    = 6'b001111;
  localparam logic [5:0]      ST_MEM   = 6'b011111;
  localparam logic [MC_W-1:0] MC_ONE   = MC_W'(1);

  state_t          r_state;
  state_t          w_state_nx;
  logic [MC_W-1:0] r_mc_cnt;
  logic [MC_W-1:0] w_mc_cnt_nx;
  logic [7:0]      r_wait_cnt;
  logic            r_flush_pend;
  logic [31:0]     r_flush_pc;
  logic            r_ex_mc_done;
  logic            r_bus_err;
  logic [31:0]     r_stall_cycles;

  logic            w_mem_wait;
  logic            w_timeout;
  logic            w_flush;
  logic            w_ex_busy;
  logic [5:0]      w_stall;

  assign w_mem_wait = mem_req && !mem_ack && (r_wait_cnt < TIMEOUT);
  assign w_timeout  = mem_req && !mem_ack && (r_wait_cnt >= TIMEOUT);
  // A flush latched during a MEM wait is only released once the wait ends.
  assign w_flush    = !w_mem_wait && (r_flush_pend || flush_req);
  assign w_ex_busy  = (r_state == BUSY) || ((r_state == IDLE) && ex_mc_start);

  always_comb begin
    w_stall = ST_NONE;
    if (w_flush)          w_stall = ST_NONE;
    else if (w_mem_wait)  w_stall = ST_MEM;
    else if (w_ex_busy)   w_stall = ST_EX;
    else if (stallreq_id) w_stall = ST_ID;
  end

  // Combinational outputs are gated so they read zero while reset is held.
  assign stall        = rst ? w_stall : ST_NONE;
  assign flush        = rst && w_flush;
  assign new_pc       = (rst && w_flush) ? (r_flush_pend ? r_flush_pc : flush_pc) : 32'd0;
  assign ex_mc_done   = r_ex_mc_done;
  assign bus_err      = r_bus_err;
  assign stall_cycles = r_stall_cycles;

  always_comb begin
    w_state_nx  = r_state;
    w_mc_cnt_nx = r_mc_cnt;
    if (w_flush) begin
      w_state_nx  = IDLE;
      w_mc_cnt_nx = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_mc_start) begin
            w_state_nx  = BUSY;
            w_mc_cnt_nx = (ex_mc_cycles == '0) ? MC_ONE : ex_mc_cycles;
          end
        end
        BUSY: begin
          if (!w_mem_wait) begin
            w_mc_cnt_nx = r_mc_cnt - MC_ONE;
            if (r_mc_cnt == MC_ONE) w_state_nx = DONE;
          end
        end
        DONE:    w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_mc_cnt       <= '0;
      r_wait_cnt     <= '0;
      r_flush_pend   <= 1'b0;
      r_flush_pc     <= '0;
      r_ex_mc_done   <= 1'b0;
      r_bus_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_mc_cnt     <= w_mc_cnt_nx;
      r_ex_mc_done <= (w_state_nx == DONE);
      r_bus_err    <= w_timeout;
      r_wait_cnt   <= w_mem_wait ? (r_wait_cnt + 8'd1) : 8'd0;

      if (w_flush) begin
        r_flush_pend <= 1'b0;
      end else if (flush_req && w_mem_wait && !r_flush_pend) begin
        r_flush_pend <= 1'b1;
        r_flush_pc   <= flush_pc;
      end

      if (stat_clr)
        r_stall_cycles <= '0;
      else if (w_stall[0] && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

endmodule
